// File: rtl/icache_ro_ctrl_pkg.sv
// Shared definitions for the read-only instruction cache controller:
// FSM state encoding and CP0 CACHE op codes.
package icache_ro_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOOKUP    = 3'd1,
        S_MISS_INV  = 3'd2,
        S_FILL      = 3'd3,
        S_VALIDATE  = 3'd4,
        S_REPLAY    = 3'd5,
        S_OP_LOOKUP = 3'd6,
        S_OP_EXEC   = 3'd7
    } state_e;

    localparam logic [1:0] OP_IDX_INV   = 2'd0;
    localparam logic [1:0] OP_HIT_INV   = 2'd1;
    localparam logic [1:0] OP_IDX_STTAG = 2'd2;
    localparam logic [1:0] OP_NOP       = 2'd3;

endpackage

// File: rtl/icache_ro_ctrl.sv
// Sequencing controller for the read-only I-cache set: fetch lookup, miss refill
// (invalidate, 4-beat fill, validate, replay) and CP0 CACHE ops.
module icache_ro_ctrl
    import icache_ro_ctrl_pkg::*;
#(
    parameter int PABITS = 36,
    localparam int TAGW = PABITS - 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              CpuRead,
    input  logic [PABITS-1:0] CpuAddr,
    output logic [31:0]       CpuData,
    output logic              CpuReady,
    input  logic              OpValid,
    input  logic [1:0]        OpCode,
    input  logic [PABITS-1:0] OpAddr,
    input  logic [TAGW+1:0]   OpTagData,
    output logic              OpDone,
    output logic              MemRead,
    output logic [PABITS-1:0] MemAddr,
    input  logic [31:0]       MemData,
    input  logic              MemReady,
    output logic [TAGW-1:0]   Tag,
    output logic [7:0]        Index,
    output logic [1:0]        Offset,
    output logic [7:0]        LineIndex,
    output logic [1:0]        LineOffset,
    output logic [31:0]       LineIn,
    output logic              FillLine,
    output logic              ValidateLine,
    output logic              InvalidateLine,
    output logic              StoreTag,
    output logic [TAGW+1:0]   StoreTagData,
    input  logic [31:0]       WordOut,
    input  logic              Hit,
    input  logic              Valid,
    output state_e            DbgState
);

    state_e            state_q;
    logic [TAGW-1:0]   tag_q;
    logic [7:0]        idx_q;
    logic [1:0]        off_q;
    logic [1:0]        cnt_q;
    logic [31:0]       cpu_data_q;
    logic              cpu_ready_q;
    logic              op_done_q;
    logic              mem_read_q;
    logic [PABITS-1:0] mem_addr_q;
    logic              validate_q;
    logic              invalidate_q;
    logic              store_tag_q;
    logic [TAGW+1:0]   store_tag_data_q;

    logic [PABITS-1:0] req_addr;
    logic              accept;
    logic              unused_bits;

    // A requester holds its request through the cycle its completion pulse is
    // visible, so a request seen while that pulse is high is the one just served.
    assign req_addr = OpValid ? OpAddr : CpuAddr;
    assign accept   = (state_q == S_IDLE) && !cpu_ready_q && !op_done_q && (OpValid || CpuRead);

    // The set registers its address, so IDLE presents the new address directly
    // to make the hit result available in the following cycle.
    assign Tag    = accept ? req_addr[PABITS-1:12] : tag_q;
    assign Index  = accept ? req_addr[11:4]        : idx_q;
    assign Offset = accept ? req_addr[3:2]         : off_q;

    assign LineIndex  = idx_q;
    assign LineOffset = cnt_q;
    assign LineIn     = MemData;
    assign FillLine   = (state_q == S_FILL) && MemReady;

    assign CpuData        = cpu_data_q;
    assign CpuReady       = cpu_ready_q;
    assign OpDone         = op_done_q;
    assign MemRead        = mem_read_q;
    assign MemAddr        = mem_addr_q;
    assign ValidateLine   = validate_q;
    assign InvalidateLine = invalidate_q;
    assign StoreTag       = store_tag_q;
    assign StoreTagData   = store_tag_data_q;
    assign DbgState       = state_q;

    // Hit alone decides a miss; Valid carries no extra information here.
    assign unused_bits = ^{Valid, req_addr[1:0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= S_IDLE;
            tag_q            <= '0;
            idx_q            <= '0;
            off_q            <= '0;
            cnt_q            <= '0;
            cpu_data_q       <= '0;
            cpu_ready_q      <= 1'b0;
            op_done_q        <= 1'b0;
            mem_read_q       <= 1'b0;
            mem_addr_q       <= '0;
            validate_q       <= 1'b0;
            invalidate_q     <= 1'b0;
            store_tag_q      <= 1'b0;
            store_tag_data_q <= '0;
        end else begin
            cpu_ready_q  <= 1'b0;
            op_done_q    <= 1'b0;
            validate_q   <= 1'b0;
            invalidate_q <= 1'b0;
            store_tag_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        tag_q <= req_addr[PABITS-1:12];
                        idx_q <= req_addr[11:4];
                        off_q <= req_addr[3:2];
                        if (OpValid) begin
                            case (OpCode)
                                OP_IDX_INV: begin
                                    state_q      <= S_OP_EXEC;
                                    invalidate_q <= 1'b1;
                                    op_done_q    <= 1'b1;
                                end
                                OP_HIT_INV: state_q <= S_OP_LOOKUP;
                                OP_IDX_STTAG: begin
                                    state_q          <= S_OP_EXEC;
                                    store_tag_q      <= 1'b1;
                                    store_tag_data_q <= OpTagData;
                                    op_done_q        <= 1'b1;
                                end
                                default: op_done_q <= 1'b1;
                            endcase
                        end else begin
                            state_q <= S_LOOKUP;
                        end
                    end
                end
                S_LOOKUP: begin
                    if (Hit) begin
                        cpu_ready_q <= 1'b1;
                        cpu_data_q  <= WordOut;
                        state_q     <= S_IDLE;
                    end else begin
                        invalidate_q <= 1'b1;
                        state_q      <= S_MISS_INV;
                    end
                end
                S_MISS_INV: begin
                    state_q    <= S_FILL;
                    mem_read_q <= 1'b1;
                    mem_addr_q <= {tag_q, idx_q, 2'b00, 2'b00};
                    cnt_q      <= 2'd0;
                end
                S_FILL: begin
                    if (MemReady) begin
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            mem_read_q <= 1'b0;
                            validate_q <= 1'b1;
                            state_q    <= S_VALIDATE;
                        end else begin
                            mem_addr_q <= {tag_q, idx_q, cnt_q + 2'd1, 2'b00};
                        end
                    end
                end
                S_VALIDATE: state_q <= S_REPLAY;
                S_REPLAY:   state_q <= S_LOOKUP;
                S_OP_LOOKUP: begin
                    op_done_q <= 1'b1;
                    if (Hit) begin
                        invalidate_q <= 1'b1;
                        state_q      <= S_OP_EXEC;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_OP_EXEC: state_q <= S_IDLE;
                default:   state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_ro_ctrl.sv
// Bench for icache_ro_ctrl with a behavioural 256x4-word set and a wait-state memory.
module tb_icache_ro_ctrl;
    import icache_ro_ctrl_pkg::*;

    logic        clock;
    logic        reset;
    logic        CpuRead;
    logic [35:0] CpuAddr;
    logic [31:0] CpuData;
    logic        CpuReady;
    logic        OpValid;
    logic [1:0]  OpCode;
    logic [35:0] OpAddr;
    logic [25:0] OpTagData;
    logic        OpDone;
    logic        MemRead;
    logic [35:0] MemAddr;
    logic [31:0] MemData;
    logic        MemReady;
    logic [23:0] Tag;
    logic [7:0]  Index;
    logic [1:0]  Offset;
    logic [7:0]  LineIndex;
    logic [1:0]  LineOffset;
    logic [31:0] LineIn;
    logic        FillLine;
    logic        ValidateLine;
    logic        InvalidateLine;
    logic        StoreTag;
    logic [25:0] StoreTagData;
    logic [31:0] WordOut;
    logic        Hit;
    logic        Valid;
    state_e      DbgState;

    int checks;
    int failures;
    int mem_waits;
    int wcnt;
    logic set_clr;

    icache_ro_ctrl #(.PABITS(36)) dut (
        .clock(clock), .reset(reset),
        .CpuRead(CpuRead), .CpuAddr(CpuAddr), .CpuData(CpuData), .CpuReady(CpuReady),
        .OpValid(OpValid), .OpCode(OpCode), .OpAddr(OpAddr), .OpTagData(OpTagData), .OpDone(OpDone),
        .MemRead(MemRead), .MemAddr(MemAddr), .MemData(MemData), .MemReady(MemReady),
        .Tag(Tag), .Index(Index), .Offset(Offset),
        .LineIndex(LineIndex), .LineOffset(LineOffset), .LineIn(LineIn),
        .FillLine(FillLine), .ValidateLine(ValidateLine), .InvalidateLine(InvalidateLine),
        .StoreTag(StoreTag), .StoreTagData(StoreTagData),
        .WordOut(WordOut), .Hit(Hit), .Valid(Valid), .DbgState(DbgState)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Set model: registered read, writes land at the same edge.
    logic [31:0] set_data [0:255][0:3];
    logic [23:0] set_tag  [0:255];
    logic        set_vld  [0:255];

    always @(posedge clock) begin
        WordOut <= set_data[Index][Offset];
        Hit     <= set_vld[Index] && (set_tag[Index] == Tag);
        Valid   <= set_vld[Index];
        if (FillLine) set_data[LineIndex][LineOffset] <= LineIn;
        if (InvalidateLine) set_vld[Index] <= 1'b0;
        if (ValidateLine) begin
            set_vld[Index] <= 1'b1;
            set_tag[Index] <= Tag;
        end
        if (StoreTag) begin
            set_tag[Index] <= StoreTagData[25:2];
            set_vld[Index] <= |StoreTagData[1:0];
        end
        if (set_clr) begin
            for (int i = 0; i < 256; i++) set_vld[i] <= 1'b0;
        end
    end

    function automatic logic [31:0] mem_word(input logic [35:0] a);
        if (a[35:12] == 24'h654321) return 32'h11111111 * (32'(a[3:2]) + 32'd1);
        return a[31:0];
    endfunction

    always @(posedge clock) begin
        MemReady <= 1'b0;
        if (reset) begin
            wcnt <= 0;
        end else if (MemRead && !MemReady) begin
            if (wcnt >= mem_waits) begin
                MemReady <= 1'b1;
                MemData  <= mem_word(MemAddr);
                wcnt     <= 0;
            end else begin
                wcnt <= wcnt + 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        is_op;
        logic [1:0]  code;
        logic [35:0] addr;
        logic [25:0] tagdata;
        int          waits;
        logic        miss;
        int          inv;
        int          stt;
        int          lat;
        logic        chk_data;
        logic [31:0] data;
    } vec_t;

    function automatic vec_t mk(input logic is_op, input logic [1:0] code, input logic [35:0] addr,
                                input logic [25:0] tagdata, input int waits, input logic miss,
                                input int inv, input int stt, input int lat,
                                input logic chk_data, input logic [31:0] data);
        vec_t v;
        v.is_op = is_op; v.code = code; v.addr = addr; v.tagdata = tagdata; v.waits = waits;
        v.miss = miss; v.inv = inv; v.stt = stt; v.lat = lat; v.chk_data = chk_data; v.data = data;
        return v;
    endfunction

    task automatic run_vec(input string nm, input vec_t v);
        int lat, fills, invs, vals, stts, mrd, both;
        logic got;
        logic [31:0] data;
        logic [1:0] exp_off;
        lat = 0; fills = 0; invs = 0; vals = 0; stts = 0; mrd = 0; both = 0;
        got = 1'b0; data = '0; exp_off = 2'd0;
        @(negedge clock);
        mem_waits = v.waits;
        if (v.is_op) begin
            OpValid = 1'b1; OpCode = v.code; OpAddr = v.addr; OpTagData = v.tagdata;
        end else begin
            CpuRead = 1'b1; CpuAddr = v.addr;
        end
        while (!got && lat < 200) begin
            @(posedge clock); #1;
            lat++;
            if (FillLine) begin
                chk({nm, " fill_off"}, 64'(LineOffset), 64'(exp_off));
                exp_off = exp_off + 2'd1;
                fills++;
            end
            if (InvalidateLine) invs++;
            if (ValidateLine) vals++;
            if (StoreTag) stts++;
            if (MemRead) mrd++;
            if (CpuReady && OpDone) both++;
            if (v.is_op ? OpDone : CpuReady) begin
                got = 1'b1;
                data = CpuData;
            end
        end
        @(negedge clock);
        CpuRead = 1'b0;
        OpValid = 1'b0;
        chk({nm, " done"}, 64'(got), 64'(1));
        chk({nm, " latency"}, 64'(lat), 64'(v.lat));
        chk({nm, " fills"}, 64'(fills), v.miss ? 64'(4) : 64'(0));
        chk({nm, " validates"}, 64'(vals), v.miss ? 64'(1) : 64'(0));
        chk({nm, " memread_seen"}, 64'(mrd != 0), 64'(v.miss));
        chk({nm, " invalidates"}, 64'(invs), 64'(v.inv));
        chk({nm, " storetags"}, 64'(stts), 64'(v.stt));
        chk({nm, " dual_pulse"}, 64'(both), 64'(0));
        if (v.chk_data) chk({nm, " data"}, 64'(data), 64'(v.data));
        if (v.is_op && v.code == OP_IDX_STTAG)
            chk({nm, " sttag_data"}, 64'(StoreTagData), 64'(v.tagdata));
    endtask

    vec_t vecs[15];
    int op_at, cpu_at, cyc, both, fills;
    logic [31:0] pdata;

    initial begin
        checks = 0; failures = 0; mem_waits = 2;
        reset = 1'b1; set_clr = 1'b1;
        CpuRead = 1'b0; CpuAddr = '0; OpValid = 1'b0; OpCode = '0; OpAddr = '0; OpTagData = '0;

        //            op   code          addr           tagdata              W  miss inv stt lat chk  data
        vecs[0]  = mk(1'b0, 2'd0,         36'h654321764, 26'h0,               2, 1'b1, 1, 0, 22, 1'b1, 32'h22222222);
        vecs[1]  = mk(1'b0, 2'd0,         36'h65432176c, 26'h0,               2, 1'b0, 0, 0,  2, 1'b1, 32'h44444444);
        vecs[2]  = mk(1'b0, 2'd0,         36'h654321760, 26'h0,               2, 1'b0, 0, 0,  2, 1'b1, 32'h11111111);
        vecs[3]  = mk(1'b0, 2'd0,         36'hcccccc764, 26'h0,               1, 1'b1, 1, 0, 18, 1'b1, 32'hccccc764);
        vecs[4]  = mk(1'b1, OP_HIT_INV,   36'h654321760, 26'h0,               0, 1'b0, 0, 0,  2, 1'b0, 32'h0);
        vecs[5]  = mk(1'b0, 2'd0,         36'hcccccc768, 26'h0,               0, 1'b0, 0, 0,  2, 1'b1, 32'hccccc768);
        vecs[6]  = mk(1'b1, OP_IDX_INV,   36'h000000760, 26'h0,               0, 1'b0, 1, 0,  1, 1'b0, 32'h0);
        vecs[7]  = mk(1'b0, 2'd0,         36'hcccccc76c, 26'h0,               0, 1'b1, 1, 0, 14, 1'b1, 32'hccccc76c);
        vecs[8]  = mk(1'b1, OP_HIT_INV,   36'hcccccc760, 26'h0,               0, 1'b0, 1, 0,  2, 1'b0, 32'h0);
        vecs[9]  = mk(1'b0, 2'd0,         36'h654321768, 26'h0,               0, 1'b1, 1, 0, 14, 1'b1, 32'h33333333);
        vecs[10] = mk(1'b1, OP_IDX_STTAG, 36'h000000fe0, {24'hcccccc, 2'b11}, 0, 1'b0, 0, 1,  1, 1'b0, 32'h0);
        vecs[11] = mk(1'b0, 2'd0,         36'hccccccfe8, 26'h0,               0, 1'b0, 0, 0,  2, 1'b0, 32'h0);
        vecs[12] = mk(1'b1, OP_NOP,       36'h000000000, 26'h0,               0, 1'b0, 0, 0,  1, 1'b0, 32'h0);
        vecs[13] = mk(1'b0, 2'd0,         36'h654321764, 26'h0,               0, 1'b0, 0, 0,  2, 1'b1, 32'h22222222);
        vecs[14] = mk(1'b0, 2'd0,         36'h222222234, 26'h0,               0, 1'b1, 1, 0, 14, 1'b1, 32'h22222234);

        repeat (3) @(posedge clock);
        #1;
        chk("reset CpuReady", 64'(CpuReady), 64'(0));
        chk("reset OpDone", 64'(OpDone), 64'(0));
        chk("reset MemRead", 64'(MemRead), 64'(0));
        chk("reset MemAddr", 64'(MemAddr), 64'(0));
        chk("reset CpuData", 64'(CpuData), 64'(0));
        chk("reset strobes", 64'({FillLine, ValidateLine, InvalidateLine, StoreTag}), 64'(0));
        chk("reset set_addr", 64'({Tag, Index, Offset, LineIndex, LineOffset}), 64'(0));
        chk("reset state", 64'(DbgState), 64'(S_IDLE));
        @(negedge clock);
        reset = 1'b0; set_clr = 1'b0;

        for (int i = 0; i < 15; i++) run_vec($sformatf("v%0d", i), vecs[i]);

        // Simultaneous op and fetch: the op completes first, pulses never overlap.
        @(negedge clock);
        OpValid = 1'b1; OpCode = OP_HIT_INV; OpAddr = 36'h111111100; OpTagData = '0;
        CpuRead = 1'b1; CpuAddr = 36'h654321764;
        op_at = 0; cpu_at = 0; cyc = 0; both = 0; pdata = '0;
        while ((op_at == 0 || cpu_at == 0) && cyc < 100) begin
            @(posedge clock); #1;
            cyc++;
            if (CpuReady && OpDone) both++;
            if (OpDone && op_at == 0) op_at = cyc;
            if (CpuReady && cpu_at == 0) begin
                cpu_at = cyc;
                pdata = CpuData;
            end
            @(negedge clock);
            if (op_at != 0) OpValid = 1'b0;
            if (cpu_at != 0) CpuRead = 1'b0;
        end
        chk("prio op_done_seen", 64'(op_at != 0), 64'(1));
        chk("prio cpu_ready_seen", 64'(cpu_at != 0), 64'(1));
        chk("prio op_latency", 64'(op_at), 64'(2));
        chk("prio op_first", 64'(op_at < cpu_at), 64'(1));
        chk("prio dual_pulse", 64'(both), 64'(0));
        chk("prio data", 64'(pdata), 64'(32'h22222222));

        // Reset while waiting for fill beat 2 of line 0x23 (tag 111111).
        @(negedge clock);
        mem_waits = 2; CpuRead = 1'b1; CpuAddr = 36'h111111238;
        fills = 0; cyc = 0;
        while (fills < 2 && cyc < 200) begin
            @(posedge clock); #1;
            cyc++;
            if (FillLine) fills++;
        end
        chk("rst beats_before", 64'(fills), 64'(2));
        @(posedge clock); #1;
        chk("rst memread_before", 64'(MemRead), 64'(1));
        @(negedge clock);
        reset = 1'b1; CpuRead = 1'b0;
        @(posedge clock); #1;
        chk("rst memread_drop", 64'(MemRead), 64'(0));
        chk("rst state", 64'(DbgState), 64'(S_IDLE));
        @(negedge clock);
        reset = 1'b0;

        run_vec("rst_old_tag", mk(1'b0, 2'd0, 36'h222222234, 26'h0, 0, 1'b1, 1, 0, 14, 1'b1, 32'h22222234));
        run_vec("rst_refetch", mk(1'b0, 2'd0, 36'h111111238, 26'h0, 0, 1'b1, 1, 0, 14, 1'b1, 32'h11111238));
        run_vec("rst_hit",     mk(1'b0, 2'd0, 36'h11111123c, 26'h0, 0, 1'b0, 0, 0,  2, 1'b1, 32'h1111123c));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
